// File: rtl/synth_cmd_spi_tx.sv
// rtl/synth_cmd_spi_tx.sv - SPI mode-0 master that frames synth commands (cmd byte + payload, MSB first).
// Optional echo compare of rx bytes against the previous tx byte: SPI_ECHO_CHECK_EN.
module synth_cmd_spi_tx #(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int IDLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_id,
  input  logic [15:0] cmd_data,
  output logic        cmd_err,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_nss,
  input  logic        spi_miso,
  output logic [7:0]  rx_byte,
  output logic        rx_valid
`ifdef SPI_ECHO_CHECK_EN
  ,
  output logic        echo_err
`endif
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, TRAIL, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  left_q, left_d;
  logic [23:0] shreg_q, shreg_d;
  logic [7:0]  rxsh_q, rxsh_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        sclk_q, sclk_d;
  logic        nss_q, nss_d;
  logic        mosi_q, mosi_d;
  logic        err_q, err_d;
  logic        accept;
  logic        known_id;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign known_id  = (cmd_id == 8'd1) || (cmd_id == 8'd2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    bit_d      = bit_q;
    left_d     = left_q;
    shreg_d    = shreg_q;
    rxsh_d     = rxsh_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    nss_d      = nss_q;
    mosi_d     = mosi_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (accept) begin
          if (known_id) begin
            state_d = LEAD;
            nss_d   = 1'b0;
            bit_d   = 3'd0;
            mosi_d  = cmd_id[7];
            if (cmd_id == 8'd1) begin
              shreg_d = {cmd_id, cmd_data};
              left_d  = 2'd3;
            end else begin
              shreg_d = {cmd_id, cmd_data[7:0], 8'h00};
              left_d  = 2'd2;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LEAD: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = 16'd0;
        end
      end
      SHIFT: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cnt_d  = 16'd0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            rxsh_d = {rxsh_q[6:0], spi_miso};
          end else begin
            // The shift register runs across byte boundaries, so bit 22 is
            // always the next bit to present, including the next byte's MSB.
            shreg_d = {shreg_q[22:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            mosi_d  = shreg_q[22];
            if (bit_q == 3'd7) begin
              rx_byte_d  = rxsh_q;
              rx_valid_d = 1'b1;
              left_d     = left_q - 2'd1;
              if (left_q > 2'd1) begin
                state_d = GAP;
              end else begin
                state_d = TRAIL;
                mosi_d  = 1'b0;
              end
            end
          end
        end
      end
      GAP: begin
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = 16'd0;
        end
      end
      TRAIL: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          state_d = HOLD;
          nss_d   = 1'b1;
          cnt_d   = 16'd0;
        end
      end
      HOLD: begin
        if (cnt_q == 16'(IDLE_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      left_q     <= 2'd0;
      shreg_q    <= 24'd0;
      rxsh_q     <= 8'd0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      nss_q      <= 1'b1;
      mosi_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      left_q     <= left_d;
      shreg_q    <= shreg_d;
      rxsh_q     <= rxsh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      nss_q      <= nss_d;
      mosi_q     <= mosi_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_nss  = nss_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign cmd_err  = err_q;

`ifdef SPI_ECHO_CHECK_EN
  logic [1:0]  idx_q, idx_d;
  logic [23:0] frame_q, frame_d;
  logic        echo_q, echo_d;
  logic [7:0]  echo_exp;

  // Byte n of the frame should echo tx byte n-1; byte 0 has nothing to echo.
  assign echo_exp = (idx_q == 2'd1) ? frame_q[23:16] : frame_q[15:8];

  always_comb begin
    idx_d   = idx_q;
    frame_d = frame_q;
    echo_d  = echo_q;
    if (accept) begin
      idx_d   = 2'd0;
      frame_d = shreg_d;
      echo_d  = 1'b0;
    end else if (rx_valid_d) begin
      idx_d = idx_q + 2'd1;
      if ((idx_q != 2'd0) && (rxsh_q != echo_exp)) begin
        echo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      frame_q <= 24'd0;
      echo_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      frame_q <= frame_d;
      echo_q  <= echo_d;
    end
  end

  assign echo_err = echo_q;
`endif

endmodule

// File: tb/tb_synth_cmd_spi_tx.sv
// tb/tb_synth_cmd_spi_tx.sv - scoreboard bench for synth_cmd_spi_tx with an echoing SPI slave model.
module tb_synth_cmd_spi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_id = 8'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        spi_miso = 1'b0;
  logic        cmd_ready, cmd_err, busy, spi_sclk, spi_mosi, spi_nss, rx_valid;
  logic [7:0]  rx_byte;
`ifdef SPI_ECHO_CHECK_EN
  logic        echo_err;
`endif

  synth_cmd_spi_tx #(.CLK_DIV(4), .GAP_CYCLES(8), .IDLE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_data(cmd_data), .cmd_err(cmd_err), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_nss(spi_nss), .spi_miso(spi_miso),
    .rx_byte(rx_byte), .rx_valid(rx_valid)
`ifdef SPI_ECHO_CHECK_EN
    , .echo_err(echo_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  bit         corrupt = 1'b0;

  // Slave answers 0x5A on byte 0, then echoes the previous byte it received.
  task automatic push_exp(input logic [7:0] id, input logic [15:0] d);
    if (id == 8'd1) begin
      exp_mosi.push_back(id);
      exp_mosi.push_back(d[15:8]);
      exp_mosi.push_back(d[7:0]);
      exp_rx.push_back(8'h5A);
      exp_rx.push_back(corrupt ? 8'h00 : id);
      exp_rx.push_back(d[15:8]);
    end else if (id == 8'd2) begin
      exp_mosi.push_back(id);
      exp_mosi.push_back(d[7:0]);
      exp_rx.push_back(8'h5A);
      exp_rx.push_back(corrupt ? 8'h00 : id);
    end
  endtask

  int         cyc = 0;
  int         rises = 0;
  int         rxv = 0;
  int         nss_rises = 0;
  int         low_run = 0;
  int         high_run = 0;
  int         last_low_len = 0;
  int         last_high_len = 0;
  int         rise_cyc = 0;
  int         ready_gap = 0;
  int         slv_bit = 0;
  int         byte_in_frame = 0;
  logic [7:0] cap = 8'd0;
  logic [7:0] cur = 8'h5A;
  logic       prev_sclk = 1'b0;
  logic       prev_nss = 1'b1;
  logic       prev_ready = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (spi_nss) begin
      slv_bit = 0;
      byte_in_frame = 0;
      cur = 8'h5A;
      high_run++;
      if (!prev_nss) begin
        last_low_len = low_run;
        low_run = 0;
        rise_cyc = cyc;
        nss_rises++;
      end
    end else begin
      low_run++;
      if (prev_nss) begin
        last_high_len = high_run;
        high_run = 0;
      end
      if (spi_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[6:0], spi_mosi};
      end
      if (!spi_sclk && prev_sclk) begin
        slv_bit++;
        if (slv_bit == 8) begin
          slv_bit = 0;
          byte_in_frame++;
          if (exp_mosi.size() == 0) check("mosi_extra", 32'(cap), 32'h100);
          else check("mosi_byte", 32'(cap), 32'(exp_mosi.pop_front()));
          cur = (corrupt && byte_in_frame == 1) ? 8'h00 : cap;
        end
      end
    end
    if (rx_valid) begin
      rxv++;
      if (exp_rx.size() == 0) check("rx_extra", 32'(rx_byte), 32'h100);
      else check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
    end
    if (cmd_ready && !prev_ready) ready_gap = cyc - rise_cyc;
    spi_miso = cur[7 - slv_bit];
    prev_sclk = spi_sclk;
    prev_nss = spi_nss;
    prev_ready = cmd_ready;
  end

  task automatic send(input logic [7:0] id, input logic [15:0] d);
    int t = 0;
    while (!cmd_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", 32'(t < 1000), 32'd1);
    push_exp(id, d);
    cmd_valid = 1'b1;
    cmd_id = id;
    cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_id = 8'hFF;
    cmd_data = 16'hFFFF;
  endtask

  task automatic wait_frame(input int target);
    int t = 0;
    while (nss_rises < target && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done", 32'(nss_rises >= target), 32'd1);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    check("ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int r0, v0, f0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_nss", 32'(spi_nss), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_rxv", 32'(rx_valid), 32'd0);
    check("rst_rxb", 32'(rx_byte), 32'd0);
    check("rst_ready_in_reset", 32'(cmd_ready), 32'd0);
`ifdef SPI_ECHO_CHECK_EN
    check("rst_echo", 32'(echo_err), 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    r0 = rises; v0 = rxv; f0 = nss_rises;
    send(8'd1, 16'h1234);
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_ready_low", 32'(cmd_ready), 32'd0);
    wait_frame(f0 + 1);
    check("f1_rises", 32'(rises - r0), 32'd24);
    check("f1_rxv", 32'(rxv - v0), 32'd3);
    check("f1_nss_len", 32'(last_low_len), 32'd216);
    check("f1_q_empty", 32'(exp_mosi.size() + exp_rx.size()), 32'd0);
    wait_ready();
    check("f1_ready_gap", 32'(ready_gap), 32'd16);
    check("f1_busy_end", 32'(busy), 32'd0);
`ifdef SPI_ECHO_CHECK_EN
    check("f1_echo_ok", 32'(echo_err), 32'd0);
`endif

    r0 = rises; v0 = rxv; f0 = nss_rises;
    send(8'd2, 16'hBEA5);
    wait_frame(f0 + 1);
    check("f2_rises", 32'(rises - r0), 32'd16);
    check("f2_rxv", 32'(rxv - v0), 32'd2);
    check("f2_nss_len", 32'(last_low_len), 32'd144);
    wait_ready();

    r0 = rises; f0 = nss_rises;
    send(8'd7, 16'h5555);
    check("bad_err_pulse", 32'(cmd_err), 32'd1);
    check("bad_nss", 32'(spi_nss), 32'd1);
    check("bad_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("bad_err_clear", 32'(cmd_err), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("bad_no_sclk", 32'(rises - r0), 32'd0);
    check("bad_no_frame", 32'(nss_rises - f0), 32'd0);

    r0 = rises; f0 = nss_rises;
    send(8'd1, 16'h1234);
    repeat (20) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_id = 8'd1;
    cmd_data = 16'h0001;
    push_exp(8'd1, 16'h0001);
    wait_frame(f0 + 1);
    begin
      int t = 0;
      while (spi_nss && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check("held_started", 32'(t < 100), 32'd1);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("held_gap", 32'(last_high_len), 32'd17);
    wait_frame(f0 + 2);
    check("held_rises", 32'(rises - r0), 32'd48);
    check("held_q_empty", 32'(exp_mosi.size() + exp_rx.size()), 32'd0);
    wait_ready();

`ifdef SPI_ECHO_CHECK_EN
    f0 = nss_rises;
    corrupt = 1'b1;
    send(8'd1, 16'h1234);
    wait_frame(f0 + 1);
    check("echo_set", 32'(echo_err), 32'd1);
    corrupt = 1'b0;
    wait_ready();
    check("echo_sticky", 32'(echo_err), 32'd1);
    send(8'd7, 16'h0000);
    check("echo_clear", 32'(echo_err), 32'd0);
    wait_ready();
`endif

    r0 = rises;
    send(8'd1, 16'h1234);
    begin
      int t = 0;
      while ((rises - r0) < 10 && t < 1000) begin
        @(posedge clk); #1;
        t++;
      end
      check("mid_reached", 32'(t < 1000), 32'd1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_nss", 32'(spi_nss), 32'd1);
    check("mid_sclk", 32'(spi_sclk), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_ready", 32'(cmd_ready), 32'd1);
    exp_mosi.delete();
    exp_rx.delete();
    v0 = rxv; r0 = rises;
    repeat (300) @(posedge clk);
    #1;
    check("mid_no_rxv", 32'(rxv - v0), 32'd0);
    check("mid_no_sclk", 32'(rises - r0), 32'd0);
    check("mid_idle_nss", 32'(spi_nss), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synth_cmd_spi_tx.md
Name: synth_cmd_spi_tx

Overview:
- SPI master (initiator) that drives the synth's SPI command link from the control side.
- Accepts one command per handshake and serialises it as a frame: command byte, then payload bytes, MSB first.
  - Command 1 (frequency): 3 bytes, cmd + freq[15:8] + freq[7:0].
  - Command 2 (envelope): 2 bytes, cmd + env[7:0].
- Feeds the DDS synth's SPI slave port. Also used as the bench driver for that port.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 2.
- GAP_CYCLES, 8, clk cycles between bytes within a frame, with nss held low and sclk low; must be >= 1.
- IDLE_CYCLES, 16, minimum clk cycles nss stays high between frames; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted
- cmd_id  in  8  command byte (1 = freq, 2 = env)
- cmd_data  in  16  payload; freq uses [15:0], env uses [7:0]
- cmd_err  out  1  one-cycle pulse when an unknown cmd_id is rejected
- busy  out  1  high from the accept cycle until the end of the idle hold
- spi_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_mosi  out  1  serial data out
- spi_nss  out  1  active-low slave select
- spi_miso  in  1  serial data in
- rx_byte  out  8  last byte sampled on MISO
- rx_valid  out  1  one-cycle pulse per completed byte

Behaviour:
- Reset values: spi_nss=1, spi_sclk=0, spi_mosi=0, cmd_ready=1, busy=0, cmd_err=0, rx_valid=0, rx_byte=0. All internal counters are cleared.
- Reset asserted mid-frame: on the next clk edge spi_nss=1 and spi_sclk=0. The partial frame is abandoned with no completion pulse.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && !reset.
  - cmd_id and cmd_data are latched at accept; later input changes are ignored.
- Unknown cmd_id (anything other than 1 or 2):
  - is accepted (consumed);
  - cmd_err pulses for one cycle in the following cycle;
  - no frame is sent, nss stays high, and the block remains in IDLE.
- State machine: IDLE -> LEAD -> SHIFT -> (GAP -> SHIFT)* -> TRAIL -> HOLD -> IDLE.
  - IDLE: nss=1. On a valid accept: nss goes 0 in the next cycle, byte count = 3 (cmd 1) or 2 (cmd 2), and the bit-7 value of the cmd byte is placed on mosi.
  - LEAD: hold for CLK_DIV cycles with sclk=0, then enter SHIFT.
  - SHIFT: 8 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
    - mosi changes only while sclk is low, at the start of each low half.
    - miso is sampled on the clk edge where sclk rises; 8 samples form rx_byte, MSB first.
    - After the 8th high half, sclk returns to 0, rx_byte updates and rx_valid pulses in the same cycle.
    - If more bytes remain, go to GAP; otherwise go to TRAIL.
  - GAP: GAP_CYCLES cycles with sclk=0, nss=0. The next byte's MSB is driven on mosi in the first GAP cycle.
  - TRAIL: CLK_DIV cycles with sclk=0, nss=0, then nss goes to 1.
  - HOLD: nss=1 for IDLE_CYCLES, then IDLE (cmd_ready=1).
- Frame length in clk cycles: CLK_DIV + N·16·CLK_DIV + (N−1)·GAP_CYCLES + CLK_DIV. For N=3, CLK_DIV=4, GAP_CYCLES=8: 216.
- cmd_valid held during busy: ignored, no queueing. The request is accepted on the first IDLE cycle.
- spi_mosi returns to 0 in TRAIL.
- Outputs are registered; no combinational path from inputs to SPI pins.

Optional Feature:
- Macro: SPI_ECHO_CHECK_EN.
- Defined:
  - Adds output echo_err (1 bit), reset value 0.
  - For every byte n>=1 of a frame, the received rx_byte is compared with transmitted byte n−1. This matches the slave's loop of received data back to MISO.
  - A mismatch sets echo_err sticky until the next accepted command or reset.
  - Byte 0 is never checked.
- Undefined: the echo_err port and the compare logic are absent; rx_byte and rx_valid are unchanged.

Test Plan:
- CLK_DIV=4, GAP_CYCLES=8. cmd_id=1, cmd_data=0x1234 -> nss low for 24 sclk rising edges; MOSI bytes 0x01, 0x12, 0x34; 3 rx_valid pulses; nss low exactly 216 cycles; cmd_ready returns 16 cycles after nss rises.
- cmd_id=2, cmd_data=0xBEA5 -> 16 sclk edges; MOSI 0x02, 0xA5 (upper byte ignored); 2 rx_valid pulses.
- cmd_id=7 -> cmd_err one-cycle pulse, nss stays 1, zero sclk edges, cmd_ready high again next cycle.
- cmd_valid held with cmd_id=1, data 0x0001 during an active frame -> no acceptance until IDLE; second frame starts after HOLD and carries 0x01, 0x00, 0x01.
- reset asserted at the 10th sclk rise of a cmd 1 frame -> next cycle nss=1, sclk=0, cmd_ready=1, no further rx_valid.
- SPI_ECHO_CHECK_EN: a MISO model returning the previous byte gives echo_err=0. Corrupting byte 1's echo to 0x00 during cmd_data=0x1234 gives echo_err=1 after byte 1's rx_valid, which clears on the next accept.
